ftdi_st_rx_buffer: RTL

Elastic byte buffer between the FTDI FIFO receive stream adapter and the Qsys bytes-to-packets input. It absorbs bursts from the FT245 read side while the Avalon-ST packet core stalls. It asserts back-pressure early so that bytes already in flight from the FT245 read cycle are never lost. Overflow and occupancy are reported for debug.

---
 rtl/ftdi_st_rx_buffer.sv | 116 +++++++++++
 1 files changed

// File: rtl/ftdi_st_rx_buffer.sv
// Elastic byte FIFO between the FTDI receive adapter and the Avalon-ST packet core, with early back-pressure.
// Optional debug statistics (byte counter, high-water mark) are built only when FTDI_RX_BUF_STATS_EN is defined.
module ftdi_st_rx_buffer #(
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 2,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iST_VALID,
  input  logic [7:0]    iST_DATA,
  output logic          oST_READY,
  output logic          oST_VALID,
  output logic [7:0]    oST_DATA,
  input  logic          iST_READY,
  input  logic          iFLUSH,
  output logic [AW:0]   oLEVEL,
  output logic          oEMPTY,
  output logic          oFULL,
  output logic          oOVF,
  output logic [31:0]   oBYTE_CNT,
  output logic [AW:0]   oMAX_LEVEL
);

  localparam int          LVL_W     = AW + 1;
  localparam logic [AW:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [AW:0] LVL_AFULL = LVL_W'(DEPTH - AFULL_MARGIN);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic [AW:0]   level_next;
  logic          ready_r;
  logic          ovf_r;
  logic          push;
  logic          pop;
  logic          drop;

  // A flush swallows any same-cycle transfer; a pop frees a slot for a push even at full.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch can be inferred.
    pop        = oST_VALID & iST_READY & ~iFLUSH;
    push       = iST_VALID & ~iFLUSH & ((level != LVL_FULL) | pop);
    drop       = iST_VALID & ~iFLUSH & (level == LVL_FULL) & ~pop;
    level_next = level;
    if (iFLUSH)
      level_next = '0;
    else if (push && !pop)
      level_next = level + LVL_W'(1);
    else if (pop && !push)
      level_next = level - LVL_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ovf_r   <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      ready_r <= (level_next < LVL_AFULL);
      level   <= level_next;
      if (iFLUSH) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf_r  <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (drop) ovf_r  <= 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by level, and the output is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= iST_DATA;
  end

  assign oST_VALID = (level != '0);
  assign oST_DATA  = oST_VALID ? mem[rd_ptr] : 8'h00;
  assign oST_READY = ready_r;
  assign oLEVEL    = level;
  assign oEMPTY    = (level == '0);
  assign oFULL     = (level == LVL_FULL);
  assign oOVF      = ovf_r;

`ifdef FTDI_RX_BUF_STATS_EN
  logic [31:0] byte_cnt;
  logic [AW:0] max_level;

  // Byte count survives a flush; the high-water mark restarts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt  <= '0;
      max_level <= '0;
    end else begin
      if (push) byte_cnt <= byte_cnt + 32'd1;
      if (iFLUSH)
        max_level <= '0;
      else if (level_next > max_level)
        max_level <= level_next;
    end
  end

  assign oBYTE_CNT  = byte_cnt;
  assign oMAX_LEVEL = max_level;
`else
  assign oBYTE_CNT  = '0;
  assign oMAX_LEVEL = '0;
`endif

endmodule
